rrp_otf_convert: RTL and testbench

- Digit-serial, most-significant-digit-first converter from radix-RADIX signed-digit (redundant) form to conventional two's-complement binary.
- It is the decoding end of the redundant datapath: it takes the digit stream produced by rRp_add and its online-arithmetic successors and returns a plain binary integer for the host/Avalon side.
- Conversion uses on-the-fly conversion: two registers, Q (the prefix value) and QM (Q-1), so no carry propagation is needed per digit.

---
 rtl/rrp_otf_convert_pkg.sv | 24 ++
 rtl/rrp_otf_convert_step.sv | 47 ++++
 rtl/rrp_otf_convert.sv | 115 +++++++++++
 tb/tb_rrp_otf_convert.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/rrp_otf_convert_pkg.sv
// Shared definitions for the redundant-digit to binary converter.
//   digit_bits()    : width of one signed digit for a given radix
//   result_bits()   : signed result width for a given radix and digit count
//   ST_*            : converter FSM state encoding
//   illegal_digit() : the one unused two's-complement digit code (-RADIX)
package rrp_otf_convert_pkg;

    function automatic int digit_bits(input int radix);
        return $clog2(radix) + 1;
    endfunction

    function automatic int result_bits(input int radix, input int width);
        return width * $clog2(radix) + 1;
    endfunction

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic int illegal_digit(input int radix);
        return -radix;
    endfunction

endpackage

// File: rtl/rrp_otf_convert_step.sv
// One on-the-fly conversion step (purely combinational).
//   q_in / qm_in   : current prefix value Q and Q-1
//   digit          : signed digit q in -(RADIX-1)..(RADIX-1), -RADIX flagged
//   q_out / qm_out : updated Q and Q-1 after appending the digit
//   illegal        : digit was the illegal code -RADIX (treated as -(RADIX-1))
module rrp_otf_convert_step
    import rrp_otf_convert_pkg::*;
#(
    parameter int RADIX = 4,
    parameter int WIDTH = 16
) (
    input  logic [result_bits(RADIX, WIDTH)-1:0] q_in,
    input  logic [result_bits(RADIX, WIDTH)-1:0] qm_in,
    input  logic [digit_bits(RADIX)-1:0]         digit,
    output logic [result_bits(RADIX, WIDTH)-1:0] q_out,
    output logic [result_bits(RADIX, WIDTH)-1:0] qm_out,
    output logic                                 illegal
);
    localparam int L  = $clog2(RADIX);
    localparam int D  = digit_bits(RADIX);
    localparam int OW = result_bits(RADIX, WIDTH);

    localparam logic [D-1:0] ILLEGAL_CODE = D'(illegal_digit(RADIX));
    localparam logic [D-1:0] MOST_NEG     = D'(1 - RADIX);

    logic [D-1:0]  d_eff;
    logic [L-1:0]  d_dec_lo;
    logic          neg;
    logic          pos;
    logic [OW-1:0] q_base;
    logic [OW-1:0] qm_base;

    always_comb begin
        illegal  = (digit == ILLEGAL_CODE);
        d_eff    = illegal ? MOST_NEG : digit;
        neg      = d_eff[D-1];
        pos      = !neg && (d_eff != '0);
        // RADIX is a power of two, so RADIX+q and q share their low L bits,
        // and likewise RADIX-1+q and q-1: one appended field serves both cases.
        d_dec_lo = d_eff[L-1:0] - L'(1);
        q_base   = neg ? qm_in : q_in;
        qm_base  = pos ? q_in  : qm_in;
        q_out    = (q_base  << L) | OW'(d_eff[L-1:0]);
        qm_out   = (qm_base << L) | OW'(d_dec_lo);
    end

endmodule

// File: rtl/rrp_otf_convert.sv
// MSD-first radix-RADIX signed-digit to two's-complement converter.
//   clock, reset_n           : rising-edge clock, asynchronous active-low reset
//   in_digit/in_valid/in_ready : digit stream, WIDTH digits per operand, MSD first
//   out_value/out_valid/out_ready : signed result handshake, held until accepted
//   out_err                  : illegal digit code seen in the delivered operand
module rrp_otf_convert
    import rrp_otf_convert_pkg::*;
#(
    parameter int RADIX = 4,
    parameter int WIDTH = 16
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic [digit_bits(RADIX)-1:0]         in_digit,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic [result_bits(RADIX, WIDTH)-1:0] out_value,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 out_err
);
    localparam int OW = result_bits(RADIX, WIDTH);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    logic [1:0]    state_reg,   state_next;
    logic [CW-1:0] count_reg,   count_next;
    logic [OW-1:0] q_reg,       q_next;
    logic [OW-1:0] qm_reg,      qm_next;
    logic          err_reg,     err_next;
    logic [OW-1:0] result_reg,  result_next;
    logic          out_err_reg, out_err_next;

    logic          accept;
    logic          start;
    logic          last;
    logic          err_merged;
    logic [OW-1:0] step_q_in, step_qm_in, step_q_out, step_qm_out;
    logic          step_illegal;

    rrp_otf_convert_step #(
        .RADIX (RADIX),
        .WIDTH (WIDTH)
    ) u_step (
        .q_in    (step_q_in),
        .qm_in   (step_qm_in),
        .digit   (in_digit),
        .q_out   (step_q_out),
        .qm_out  (step_qm_out),
        .illegal (step_illegal)
    );

    always_comb begin
        // A finished result blocks new digits only while the consumer stalls.
        in_ready   = (state_reg == ST_DONE) ? out_ready : 1'b1;
        accept     = in_valid && in_ready;
        // Outside ACCUM any accepted digit is the MSD of a fresh operand.
        start      = (state_reg != ST_ACCUM);
        step_q_in  = start ? '0 : q_reg;
        step_qm_in = start ? '1 : qm_reg;
        last       = start ? (WIDTH == 1) : (count_reg == LAST_COUNT);
        err_merged = (start ? 1'b0 : err_reg) | step_illegal;

        state_next   = state_reg;
        count_next   = count_reg;
        q_next       = q_reg;
        qm_next      = qm_reg;
        err_next     = err_reg;
        result_next  = result_reg;
        out_err_next = out_err_reg;

        if (accept) begin
            q_next     = step_q_out;
            qm_next    = step_qm_out;
            err_next   = err_merged;
            count_next = start ? CW'(1) : count_reg + CW'(1);
            if (last) begin
                state_next   = ST_DONE;
                result_next  = step_q_out;
                out_err_next = err_merged;
            end else begin
                state_next = ST_ACCUM;
            end
        end else if (state_reg == ST_DONE && out_ready) begin
            state_next = ST_IDLE;
        end else if (state_reg != ST_ACCUM && state_reg != ST_DONE) begin
            state_next = ST_IDLE;
        end

        out_valid = (state_reg == ST_DONE);
        out_value = result_reg;
        out_err   = out_err_reg;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            count_reg   <= '0;
            q_reg       <= '0;
            qm_reg      <= '1;
            err_reg     <= 1'b0;
            result_reg  <= '0;
            out_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            q_reg       <= q_next;
            qm_reg      <= qm_next;
            err_reg     <= err_next;
            result_reg  <= result_next;
            out_err_reg <= out_err_next;
        end
    end

endmodule

// File: tb/tb_rrp_otf_convert.sv
// Scoreboard bench for rrp_otf_convert with RADIX=4, WIDTH=4.
// The driver pushes hand-computed results when it issues an operand; a
// monitor pops and compares on every out_valid & out_ready handshake.
module tb_rrp_otf_convert;
    localparam int RADIX = 4;
    localparam int WIDTH = 4;
    localparam int D     = 3;
    localparam int OW    = 9;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [D-1:0]  in_digit = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [OW-1:0] out_value;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_err;

    int checks = 0;
    int errors = 0;
    int exp_val[$];
    int exp_err[$];

    rrp_otf_convert #(
        .RADIX (RADIX),
        .WIDTH (WIDTH)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_digit  (in_digit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_value (out_value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_err   (out_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int actual, input int required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    // Monitor: compare every delivered result against the scoreboard.
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n && out_valid && out_ready) begin
                if (exp_val.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0d, expected none",
                             $signed(out_value));
                end else begin
                    int ev;
                    int ee;
                    ev = exp_val.pop_front();
                    ee = exp_err.pop_front();
                    $display("result value=%0d err=%0d (expected %0d err=%0d)",
                             $signed(out_value), out_err, ev, ee);
                    check("result_value", int'($signed(out_value)), ev);
                    check("result_err", int'(out_err), ee);
                end
            end
        end
    end

    // Present one digit and return once it has been accepted.
    task automatic send_digit(input int d, output int waited);
        logic rdy;
        bit   done;
        in_valid = 1'b1;
        in_digit = D'(d);
        waited   = 0;
        done     = 1'b0;
        while (!done) begin
            @(negedge clock);
            rdy = in_ready;
            @(posedge clock);
            #1;
            if (rdy) begin
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 50) begin
                    checks++;
                    errors++;
                    $display("FAIL digit_accept_timeout: got no accept, expected accept within 50 cycles");
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic send_op(input int d0, input int d1, input int d2, input int d3,
                           input int value, input int err, output int stalls);
        int ds[4];
        int w;
        ds = '{d0, d1, d2, d3};
        exp_val.push_back(value);
        exp_err.push_back(err);
        stalls = 0;
        for (int i = 0; i < 4; i++) begin
            send_digit(ds[i], w);
            stalls += w;
        end
    endtask

    initial begin
        int st;
        int st2;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_value", int'(out_value), 0);
        check("reset_out_err", int'(out_err), 0);
        @(posedge clock);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;

        // 1*64 - 1*16 + 0*4 + 2 = 50, then all -3 = -255, back to back
        send_op(1, -1, 0, 2, 50, 0, st);
        send_op(-3, -3, -3, -3, -255, 0, st2);
        check("no_bubble_stalls", st + st2, 0);

        // all 3 = 255, also streamed without a gap
        send_op(3, 3, 3, 3, 255, 0, st);
        check("no_bubble_stalls2", st, 0);

        // Backpressure: result held, new MSD blocked for 5 cycles
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_digit  = D'(1);
        repeat (5) begin
            @(negedge clock);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_out_value", int'($signed(out_value)), 255);
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        // The held MSD is taken on release; the operand still yields 50
        send_op(1, -1, 0, 2, 50, 0, st);
        check("bp_release_stalls", st, 0);

        // Illegal -4 acts as -3: 64 + 0 - 3*4 + 0 = 52, flagged; next is clean
        send_op(1, 0, -4, 0, 52, 1, st);
        send_op(0, 0, 0, -1, -1, 0, st);

        // Reset mid-operand discards the partial prefix
        send_digit(3, st);
        send_digit(3, st);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        check("midreset_out_valid", int'(out_valid), 0);
        check("midreset_in_ready", int'(in_ready), 1);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        // 0 + 0 + 1*4 + 1 = 5
        send_op(0, 0, 1, 1, 5, 0, st);
        in_valid = 1'b0;

        // Drain: every expected result delivered, then back to idle
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (exp_val.size() == 0) break;
        end
        check("scoreboard_drained", exp_val.size(), 0);
        @(posedge clock);
        @(negedge clock);
        check("idle_out_valid", int'(out_valid), 0);
        check("idle_in_ready", int'(in_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
